// File: rtl/mem_writeback.sv
// mem_writeback: final pipeline stage. It decodes the instruction, merges the ALU
//    result with the data-memory reply, extracts the load data and drives the
//    register-file write port. It also counts retired instructions.
// Latency: rf_we/rf_waddr/rf_wdata/load_err are registered and valid the cycle
//    after an instruction completes. A load with a same-cycle reply does not stall.
// Backpressure: stall is combinational. It is held while a load waits for
//    mem_rvalid, drops in the reply cycle, and the wait gives up after TIMEOUT_CYC
//    WAIT cycles.
// Ports:
//    clk, rstn                         clock, async active-low reset
//    valid_i, alu_data, rd, ir         registered instruction from load/store stage
//    mem_rvalid, mem_rdata             data-memory read response (aligned word)
//    stall                             hold upstream pipeline register
//    rf_we, rf_waddr, rf_wdata         register-file write port
//    load_err                          one-cycle pulse on bad/misaligned/timed-out load
//    instret                           64-bit retired-instruction counter
module mem_writeback #(
   parameter int XLEN        = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int INST_WIDTH  = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  valid_i,
   input  logic [XLEN-1:0]       alu_data,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [INST_WIDTH-1:0] ir,
   input  logic                  mem_rvalid,
   input  logic [XLEN-1:0]       mem_rdata,
   output logic                  stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_waddr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  load_err,
   output logic [63:0]           instret
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Counter must hold the value TIMEOUT_CYC itself.
   localparam int              CW  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0]   TMO = CW'(TIMEOUT_CYC);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [63:0]     instret_q;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [1:0]      off;
   logic            is_load;
   logic            writes;
   logic            load_bad;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] wdata_nxt;
   logic [7:0]      byte_sel;
   logic [15:0]     half_sel;
   logic            complete;
   logic            timeout;
   logic            retire_ok;

   // ir fields outside opcode/funct3 do not affect writeback.
   logic            unused_ir;
   assign unused_ir = ^{ir[INST_WIDTH-1:15], ir[11:7]};

   assign opcode  = ir[6:0];
   assign funct3  = ir[14:12];
   assign off     = alu_data[1:0];
   assign is_load = (opcode == OP_LOAD);
   assign writes  = (opcode != OP_STORE) && (opcode != OP_BRANCH);

   // Lane select within the aligned memory word.
   assign byte_sel = mem_rdata[{off, 3'b000} +: 8];
   assign half_sel = mem_rdata[{off[1], 4'b0000} +: 16];

   always_comb begin
      ld_data  = '0;
      load_bad = 1'b0;
      case (funct3)
         3'b000: ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         3'b100: ld_data = {{(XLEN-8){1'b0}}, byte_sel};
         3'b001: begin
            ld_data  = {{(XLEN-16){half_sel[15]}}, half_sel};
            load_bad = off[0];
         end
         3'b101: begin
            ld_data  = {{(XLEN-16){1'b0}}, half_sel};
            load_bad = off[0];
         end
         3'b010: begin
            ld_data  = mem_rdata;
            load_bad = (off != 2'b00);
         end
         default: load_bad = 1'b1;
      endcase
   end

   assign wdata_nxt = is_load ? ld_data : alu_data;

   // A bad load still completes the memory handshake, but it neither writes nor retires.
   assign retire_ok = !(is_load && load_bad);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      complete  = 1'b0;
      timeout   = 1'b0;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (valid_i) begin
               if (is_load && !mem_rvalid) begin
                  stall     = 1'b1;
                  state_nxt = WAIT;
                  cnt_nxt   = CW'(1);
               end else begin
                  complete = 1'b1;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               // The reply releases the pipeline in the same cycle.
               complete  = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == TMO) begin
               stall     = 1'b1;
               timeout   = 1'b1;
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               stall   = 1'b1;
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         rf_we     <= 1'b0;
         rf_waddr  <= '0;
         rf_wdata  <= '0;
         load_err  <= 1'b0;
         instret_q <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rf_we    <= complete && writes && (rd != '0) && retire_ok;
         load_err <= (complete && !retire_ok) || timeout;
         if (complete && writes && (rd != '0) && retire_ok) begin
            rf_waddr <= rd;
            rf_wdata <= wdata_nxt;
         end
         if (complete && retire_ok) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: table of single instructions plus reset/wrap sequences.
// Writes and error pulses are checked against a queue filled at issue time.
// Stall length and instret are checked after each instruction.
module tb_mem_writeback;

   localparam int TMO = 16;

   logic        clk;
   logic        rstn;
   logic        valid_i;
   logic [31:0] alu_data;
   logic [4:0]  rd;
   logic [31:0] ir;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        stall;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        load_err;
   logic [63:0] instret;

   mem_writeback #(
      .XLEN(32), .REG_ADDR_W(5), .INST_WIDTH(32), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rstn(rstn), .valid_i(valid_i), .alu_data(alu_data), .rd(rd),
      .ir(ir), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .stall(stall),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .load_err(load_err), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        err;
   } exp_t;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          delay;      // cycles until mem_rvalid; NEVER = no reply
      int          exp_stall;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic        exp_err;
   } vec_t;

   localparam int NEVER = 255;
   localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011,
                          BRANCH = 7'b1100011, OPIMM = 7'b0010011, LUI = 7'b0110111;

   exp_t        sb[$];
   vec_t        vq[$];
   int          tests = 0;
   int          failures = 0;
   logic [63:0] exp_instret = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
      return {17'h0, f3, 5'h0, op};
   endfunction

   task automatic add(input string nm, input logic [2:0] f3, input logic [6:0] op,
                      input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                      input int dly, input int st, input logic we,
                      input logic [31:0] wd, input logic er);
      vec_t v;
      v.name = nm; v.f3 = f3; v.op = op; v.rd = r; v.alu = a; v.rdata = d;
      v.delay = dly; v.exp_stall = st; v.exp_we = we; v.exp_wdata = wd; v.exp_err = er;
      vq.push_back(v);
   endtask

   // Output monitor: every rf_we/load_err pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rstn && (rf_we || load_err)) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {rf_we, load_err}, 2'b00);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_rf_we", rf_we, e.we);
            chk("sb_load_err", load_err, e.err);
            if (e.we) begin
               chk("sb_rf_waddr", rf_waddr, e.waddr);
               chk("sb_rf_wdata", rf_wdata, e.wdata);
            end
         end
      end
   end

   // Issue one instruction at a negedge; returns at the negedge after it completes.
   task automatic run_vec(input vec_t v);
      int  stall_cnt;
      logic done;
      valid_i    = 1'b1;
      ir         = mk(v.f3, v.op);
      rd         = v.rd;
      alu_data   = v.alu;
      mem_rdata  = v.rdata;
      mem_rvalid = (v.delay == 0);
      if (v.exp_we || v.exp_err) sb.push_back('{v.exp_we, v.rd, v.exp_wdata, v.exp_err});
      if (!v.exp_err) exp_instret = exp_instret + 64'd1;
      stall_cnt = 0;
      for (int c = 0; c < TMO + 4; c++) begin
         #1;
         done = !stall;
         if (stall) stall_cnt++;
         @(posedge clk);
         @(negedge clk);
         // A timed-out load stalls for the issuing cycle plus TMO WAIT cycles.
         if (done || stall_cnt == TMO + 1) break;
         if (c + 1 == v.delay) mem_rvalid = 1'b1;
      end
      valid_i    = 1'b0;
      mem_rvalid = 1'b0;
      chk({v.name, "_stall_cycles"}, 64'(stall_cnt), 64'(v.exp_stall));
      chk({v.name, "_instret"}, instret, exp_instret);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; valid_i = 1'b0; alu_data = '0; rd = '0; ir = '0;
      mem_rvalid = 1'b0; mem_rdata = '0;

      //  name        f3      op      rd  alu           rdata         dly    st      we    wdata         err
      add("addi",     3'b000, OPIMM,  5,  32'h1234,     32'h0,        0,     0,      1'b1, 32'h1234,     1'b0);
      add("lb",       3'b000, LOAD,   7,  32'h1003,     32'h80FFFFFF, 0,     0,      1'b1, 32'hFFFFFF80, 1'b0);
      add("lbu",      3'b100, LOAD,   7,  32'h1003,     32'h80FFFFFF, 0,     0,      1'b1, 32'h00000080, 1'b0);
      add("lw_late",  3'b010, LOAD,   3,  32'h2000,     32'hDEADBEEF, 3,     3,      1'b1, 32'hDEADBEEF, 1'b0);
      add("lw_tmo",   3'b010, LOAD,   3,  32'h2000,     32'h0,        NEVER, TMO+1,  1'b0, 32'h0,        1'b1);
      add("lh_mis",   3'b001, LOAD,   4,  32'h1001,     32'h11223344, 0,     0,      1'b0, 32'h0,        1'b1);
      add("sw",       3'b010, STORE,  6,  32'h3000,     32'h0,        0,     0,      1'b0, 32'h0,        1'b0);
      add("beq",      3'b000, BRANCH, 6,  32'h3004,     32'h0,        0,     0,      1'b0, 32'h0,        1'b0);
      add("addi_x0",  3'b000, OPIMM,  0,  32'h5555,     32'h0,        0,     0,      1'b0, 32'h0,        1'b0);
      add("lh_hi",    3'b001, LOAD,   8,  32'h1002,     32'h80017FFF, 0,     0,      1'b1, 32'hFFFF8001, 1'b0);
      add("lhu_hi",   3'b101, LOAD,   8,  32'h1002,     32'h80017FFF, 1,     1,      1'b1, 32'h00008001, 1'b0);
      add("lh_lo",    3'b001, LOAD,   8,  32'h1000,     32'h80017FFF, 0,     0,      1'b1, 32'h00007FFF, 1'b0);
      add("lb_off1",  3'b000, LOAD,   9,  32'h4001,     32'h12345678, 0,     0,      1'b1, 32'h00000056, 1'b0);
      add("lw_mis",   3'b010, LOAD,   9,  32'h4002,     32'h12345678, 2,     2,      1'b0, 32'h0,        1'b1);
      add("ld_f3bad", 3'b011, LOAD,   9,  32'h4000,     32'h12345678, 0,     0,      1'b0, 32'h0,        1'b1);
      add("lui",      3'b000, LUI,    10, 32'hABCDE000, 32'h0,        0,     0,      1'b1, 32'hABCDE000, 1'b0);
      add("lw_x0",    3'b010, LOAD,   0,  32'h4000,     32'h12345678, 1,     1,      1'b0, 32'h0,        1'b0);

      repeat (2) @(negedge clk);
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 5'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_load_err", load_err, 1'b0);
      chk("rst_instret", instret, 64'd0);
      chk("rst_stall", stall, 1'b0);
      rstn = 1'b1;
      @(negedge clk);

      foreach (vq[i]) run_vec(vq[i]);

      // A reply with no load pending and a bubble are both ignored.
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
      repeat (3) @(negedge clk);
      mem_rvalid = 1'b0;
      chk("bubble_instret", instret, exp_instret);
      chk("bubble_stall", stall, 1'b0);

      // Reset in the middle of a waiting load: no write, everything cleared.
      valid_i = 1'b1; ir = mk(3'b010, LOAD); rd = 5'd3; alu_data = 32'h2000;
      mem_rdata = 32'hCAFEF00D; mem_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk("midwait_stall", stall, 1'b1);
      rstn = 1'b0;
      #1;
      chk("midrst_rf_we", rf_we, 1'b0);
      chk("midrst_rf_waddr", rf_waddr, 5'd0);
      chk("midrst_rf_wdata", rf_wdata, 32'd0);
      chk("midrst_load_err", load_err, 1'b0);
      chk("midrst_instret", instret, 64'd0);
      valid_i = 1'b0;
      #1 chk("midrst_stall", stall, 1'b0);
      exp_instret = '0;
      @(negedge clk);
      rstn = 1'b1;
      mem_rvalid = 1'b1;
      repeat (2) @(negedge clk);
      mem_rvalid = 1'b0;
      chk("postrst_instret", instret, 64'd0);
      chk("postrst_stall", stall, 1'b0);

      // instret wraps from all-ones to zero.
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.instret_q;
      #1 chk("preload_instret", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      run_vec(vq[0]);
      chk("wrap_instret_zero", instret, 64'd0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
